// File: rtl/text_console_pkg.sv
// Shared constants, state encoding and helpers for the text console writer.
package text_console_pkg;

  localparam int CHARS_PER_ROW = 64;
  localparam int ROWS          = 4;
  localparam int TEXT_DEPTH    = 256;
  localparam int CURSOR_W      = $clog2(TEXT_DEPTH);
  localparam int COL_W         = $clog2(CHARS_PER_ROW);
  localparam int ROW_W         = CURSOR_W - COL_W;

  localparam logic [7:0] BLANK = 8'h20;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  localparam logic [CURSOR_W-1:0] ROW_STEP       = CURSOR_W'(CHARS_PER_ROW);
  localparam logic [CURSOR_W-1:0] LAST_ROW_START = CURSOR_W'(TEXT_DEPTH - CHARS_PER_ROW);
  localparam logic [CURSOR_W-1:0] LAST_COPY      = CURSOR_W'(TEXT_DEPTH - CHARS_PER_ROW - 1);
  localparam logic [CURSOR_W-1:0] LAST_CELL      = CURSOR_W'(TEXT_DEPTH - 1);
  localparam logic [ROW_W-1:0]    LAST_ROW       = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Writer side of the 256-cell text buffer: places ASCII bytes at a cursor,
// interprets LF/CR/BS/FF and scrolls one row when output runs off the bottom.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | accepting bytes (char_ready high)
// SCROLL    | copying rows 1..3 up into rows 0..2, one cell per cycle
// CLEAR_ROW | blanking the last row after a scroll
// CLEAR_ALL | blanking every cell after a form feed
module text_console_writer
  import text_console_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                char_valid,
  input  logic [7:0]          char_data,
  output logic                char_ready,
  output logic [7:0]          text [255:0],
  output logic [CURSOR_W-1:0] cursor_pos,
  output logic                busy
);

  state_t              state;
  logic [CURSOR_W-1:0] idx;
  logic [CURSOR_W-1:0] src_idx;
  logic [CURSOR_W-1:0] bs_idx;
  logic [ROW_W-1:0]    row;
  logic [ROW_W-1:0]    row_next;

  assign char_ready = (state == IDLE);
  assign busy       = ~char_ready;

  assign row      = cursor_pos[CURSOR_W-1:COL_W];
  assign row_next = row + ROW_W'(1);
  assign src_idx  = idx + ROW_STEP;
  assign bs_idx   = cursor_pos - CURSOR_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      cursor_pos <= '0;
      for (int i = 0; i < TEXT_DEPTH; i++) text[i] <= BLANK;
    end else begin
      case (state)
        IDLE: begin
          if (char_valid) begin
            case (char_data)
              CH_LF: begin
                if (row == LAST_ROW) begin
                  state      <= SCROLL;
                  idx        <= '0;
                  cursor_pos <= LAST_ROW_START;
                end else begin
                  cursor_pos <= {row_next, {COL_W{1'b0}}};
                end
              end
              CH_CR: cursor_pos <= {row, {COL_W{1'b0}}};
              CH_BS: begin
                if (cursor_pos != '0) begin
                  cursor_pos   <= bs_idx;
                  text[bs_idx] <= BLANK;
                end
              end
              CH_FF: begin
                state      <= CLEAR_ALL;
                idx        <= '0;
                cursor_pos <= '0;
              end
              default: begin
                if (is_printable(char_data)) begin
                  // Write lands before any scroll so the last cell moves up with its row.
                  text[cursor_pos] <= char_data;
                  if (cursor_pos == LAST_CELL) begin
                    state      <= SCROLL;
                    idx        <= '0;
                    cursor_pos <= LAST_ROW_START;
                  end else begin
                    cursor_pos <= cursor_pos + CURSOR_W'(1);
                  end
                end
              end
            endcase
          end
        end
        SCROLL: begin
          text[idx] <= text[src_idx];
          if (idx == LAST_COPY) begin
            state <= CLEAR_ROW;
            idx   <= LAST_ROW_START;
          end else begin
            idx <= idx + CURSOR_W'(1);
          end
        end
        CLEAR_ROW, CLEAR_ALL: begin
          text[idx] <= BLANK;
          if (idx == LAST_CELL) state <= IDLE;
          else idx <= idx + CURSOR_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer.
module tb_text_console_writer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       char_valid = 1'b0;
  logic [7:0] char_data = 8'h00;
  logic       char_ready;
  logic [7:0] text [255:0];
  logic [7:0] cursor_pos;
  logic       busy;

  int checks = 0;
  int errors = 0;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .char_valid (char_valid),
    .char_data  (char_data),
    .char_ready (char_ready),
    .text       (text),
    .cursor_pos (cursor_pos),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int count_nonblank(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (text[i] !== 8'h20) n++;
    return n;
  endfunction

  function automatic logic [7:0] fill_byte(input int i);
    return 8'(8'h21 + (i % 90));
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!char_ready && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 1000) check("send_timeout", 32'(char_ready), 1);
    char_valid = 1'b1;
    char_data  = b;
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  // Counts cycles spent not ready, with a bound so a stuck FSM still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    while (!char_ready && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int  n;
    int  bad;
    @(posedge clk); #1;
    do_reset();

    check("rst_cursor", 32'(cursor_pos), 0);
    check("rst_ready", 32'(char_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_blank", count_nonblank(0, 255), 0);

    // "AB"
    check("ab_ready0", 32'(char_ready), 1);
    send_byte(8'h41);
    check("ab_ready1", 32'(char_ready), 1);
    send_byte(8'h42);
    check("ab_ready2", 32'(char_ready), 1);
    check("ab_t0", 32'(text[0]), 32'h41);
    check("ab_t1", 32'(text[1]), 32'h42);
    check("ab_cursor", 32'(cursor_pos), 2);
    check("ab_rest_blank", count_nonblank(2, 255), 0);

    // Newline from column 5, then CR after three chars on row 1
    send_byte(8'h43); send_byte(8'h44); send_byte(8'h45);
    check("lf_pre_cursor", 32'(cursor_pos), 5);
    send_byte(8'h0A);
    check("lf_cursor", 32'(cursor_pos), 64);
    send_byte(8'h78); send_byte(8'h79); send_byte(8'h7A);
    check("cr_pre_cursor", 32'(cursor_pos), 67);
    check("cr_t66", 32'(text[66]), 32'h7A);
    send_byte(8'h0D);
    check("cr_cursor", 32'(cursor_pos), 64);
    check("cr_t64_kept", 32'(text[64]), 32'h78);

    // Ignored codes: consumed, nothing changes
    send_byte(8'h01);
    send_byte(8'h7F);
    check("ign_cursor", 32'(cursor_pos), 64);
    check("ign_t64", 32'(text[64]), 32'h78);
    check("ign_ready", 32'(char_ready), 1);

    // Backspace at 0 and at 3
    do_reset();
    send_byte(8'h08);
    check("bs0_cursor", 32'(cursor_pos), 0);
    check("bs0_blank", count_nonblank(0, 255), 0);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    send_byte(8'h08);
    check("bs3_cursor", 32'(cursor_pos), 2);
    check("bs3_t2", 32'(text[2]), 32'h20);
    check("bs3_t1", 32'(text[1]), 32'h62);

    // Fill all 256 cells, last byte 0x5A triggers the scroll
    do_reset();
    for (int i = 0; i < 255; i++) send_byte(fill_byte(i));
    check("fill_cursor255", 32'(cursor_pos), 255);
    check("fill_ready_pre", 32'(char_ready), 1);
    send_byte(8'h5A);
    check("fill_t255_landed", 32'(text[255]), 32'h5A);
    check("fill_busy_start", 32'(busy), 1);
    count_busy(n);
    check("scroll_busy_cycles", n, 256);
    bad = 0;
    for (int i = 0; i < 191; i++) if (text[i] !== fill_byte(i + 64)) bad++;
    check("scroll_rows_up", bad, 0);
    check("scroll_t191", 32'(text[191]), 32'h5A);
    check("scroll_last_row_blank", count_nonblank(192, 255), 0);
    check("scroll_cursor", 32'(cursor_pos), 192);

    // Fill the last row up to 255 cells non-blank, then form feed while offering a byte during busy
    for (int i = 0; i < 63; i++) send_byte(fill_byte(i));
    check("ff_pre_cursor", 32'(cursor_pos), 255);
    check("ff_pre_full", count_nonblank(0, 255), 255);
    send_byte(8'h0C);
    char_valid = 1'b1;
    char_data  = 8'h41;
    n = 0;
    while (!char_ready && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    char_valid = 1'b0;
    check("ff_busy_cycles", n, 256);
    check("ff_all_blank", count_nonblank(0, 255), 0);
    check("ff_cursor", 32'(cursor_pos), 0);
    @(posedge clk); #1;
    check("ff_not_consumed_cursor", 32'(cursor_pos), 0);
    check("ff_not_consumed_t0", 32'(text[0]), 32'h20);

    // Reset in the middle of a scroll
    send_byte(8'h51);
    send_byte(8'h0A); send_byte(8'h0A); send_byte(8'h0A);
    check("mid_pre_cursor", 32'(cursor_pos), 192);
    send_byte(8'h0A);
    check("mid_scrolling", 32'(busy), 1);
    repeat (100) begin @(posedge clk); #1; end
    check("mid_still_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_ready", 32'(char_ready), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_cursor", 32'(cursor_pos), 0);
    check("mid_rst_blank", count_nonblank(0, 255), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Writer side of the 256-entry text buffer consumed by the VGA text pixel generator. Accepts one ASCII byte per valid/ready handshake and writes it at a cursor. Handles control codes (newline, carriage return, backspace, form feed) and scrolls the buffer up one row when output runs past the last row. Sits between the CPU's character-output port and the pixel generator's text input.

Parameters:
CHARS_PER_ROW, 64, characters per text row; must be a power of two.
ROWS, 4, text rows; CHARS_PER_ROW*ROWS = 256 = depth of text[].
BLANK, 8'h20, fill code used for cleared cells.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
char_valid  input  1  char_data holds a byte to consume.
char_data  input  8  ASCII byte.
char_ready  output  1  block can accept a byte this cycle.
text  output  8 x 256 (unpacked [255:0])  buffer; drives the pixel generator's text input.
cursor_pos  output  8  registered linear cursor index; row = [7:6], col = [5:0].
busy  output  1  high in any non-IDLE state.

Behaviour:
- Reset (rst=1 at a clk edge): all text[] = BLANK, cursor_pos = 0, state = IDLE. rst aborts any scroll or clear in progress.
- char_ready = (state==IDLE). busy = !char_ready. Both are combinational from state.
- Transfer: a byte is consumed when char_valid && char_ready at a rising edge. Every accepted byte is consumed, including ignored codes.
- States: IDLE, SCROLL, CLEAR_ROW, CLEAR_ALL. A scan index idx (8 bits) is used in the non-IDLE states.
- Accepted byte in IDLE:
  - Printable 0x20..0x7E: text[cursor] <= byte on the same edge. If cursor == 255, go to SCROLL (idx=0) and set cursor = 192. Otherwise cursor = cursor+1; crossing a row boundary wraps to the next row start.
  - 0x0A (newline): if row == 3, go to SCROLL and set cursor = 192. Otherwise cursor = (row+1)*64.
  - 0x0D (carriage return): cursor = row*64. No write.
  - 0x08 (backspace): if cursor > 0, cursor = cursor-1 and text[cursor-1] = BLANK. At cursor 0: no-op.
  - 0x0C (form feed): go to CLEAR_ALL (idx=0) and set cursor = 0.
  - All other codes: consumed, no state or buffer change.
- SCROLL: each cycle text[idx] <= text[idx+64]; idx increments. At idx == 191 (last copy), go to CLEAR_ROW with idx = 192. Duration 192 cycles.
- CLEAR_ROW: each cycle text[idx] <= BLANK. At idx == 255, return to IDLE. Duration 64 cycles.
- CLEAR_ALL: each cycle text[idx] <= BLANK, idx 0..255, then IDLE. Duration 256 cycles.
- Latency: a printable byte is visible in text[] one edge after acceptance. After a scroll-triggering byte, char_ready is low for exactly 256 cycles, then high.
- A write at cursor 255 lands before the scroll, so that character ends up at index 191 after the scroll completes.
- char_valid during busy is ignored (not consumed). The producer must hold the byte until ready.
- Pixel generator may read text[] mid-scroll; transient tearing for up to 256 cycles is accepted.
- Arithmetic: cursor and idx are 8-bit unsigned. idx+64 is only formed while idx <= 191, so it never overflows.

Decomposition:
- Package text_console_pkg holds:
  - state enum (IDLE, SCROLL, CLEAR_ROW, CLEAR_ALL);
  - control-code constants CH_LF=8'h0A, CH_CR=8'h0D, CH_BS=8'h08, CH_FF=8'h0C;
  - BLANK, CHARS_PER_ROW, ROWS, TEXT_DEPTH=256, CURSOR_W=$clog2(TEXT_DEPTH).
- No sub-module: single FSM plus buffer register array.

Test Plan:
- Reset, then send "AB" (0x41, 0x42) -> text[0]=0x41, text[1]=0x42, cursor_pos=2, all other cells 0x20, char_ready high throughout.
- Cursor at 5, send 0x0A -> cursor_pos=64. Then send 0x0D after 3 chars -> cursor_pos=64.
- Cursor 0, send 0x08 -> no change. Cursor 3, send 0x08 -> cursor_pos=2, text[2]=0x20.
- Fill 256 printable bytes, with 0x5A as the last -> char_ready low for exactly 256 cycles, then text[191]=0x5A, text[192..255]=0x20, row 0 holds former row 1, cursor_pos=192.
- Send 0x0C with a full buffer -> busy for 256 cycles, all cells 0x20, cursor_pos=0. Bytes offered with char_valid during busy are not consumed.
- Assert rst mid-SCROLL (cycle 100) -> next edge: state IDLE, all cells 0x20, cursor_pos=0, char_ready=1.
